// File: rtl/inv_sbox_serial.sv
// ---------------------------------------------------------------------------
// inv_sbox_serial
// Byte-serial inverse S-box over a 128-bit state. A state is captured on an
// input handshake, then one byte per clock is replaced by
//   y = INV(L(x ^ IN_CONST))
// where L is the inverse of the AES SubBytes linear map and INV is the
// GF(2^8) multiplicative inverse modulo 0x11B (INV(0) = 0). With the default
// IN_CONST = 8'h63 this is exactly AES InvSubBytes.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : in_data carries a state to process
//   in_ready  : block can accept a state this cycle (IDLE only)
//   in_data   : input state, byte k at bits [8k+7:8k]
//   out_valid : out_data holds a complete result (DONE only)
//   out_ready : downstream takes out_data this cycle
//   out_data  : result state, same byte order as in_data
//   busy      : high while bytes are being processed
// ---------------------------------------------------------------------------
module inv_sbox_serial #(
  parameter logic [7:0] IN_CONST = 8'h63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT        r_state;
  stateT        w_nextState;
  logic [127:0] r_data;
  logic [3:0]   r_count;
  logic [6:0]   w_bitIdx;
  logic [7:0]   w_curByte;
  logic [7:0]   w_mapped;
  logic [7:0]   w_newByte;

  // GF(2^8) multiply, shift-and-add with reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; a zero input naturally gives
  // zero, so no special case is needed.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse of the SubBytes bit matrix: each output bit is the XOR of three
  // input bits at fixed rotational offsets.
  function automatic logic [7:0] invLinear(input logic [7:0] b);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    return y;
  endfunction

  // The byte currently pointed to by the counter and its transformed value.
  assign w_bitIdx  = {r_count, 3'b000};
  assign w_curByte = r_data[w_bitIdx +: 8];
  assign w_mapped  = invLinear(w_curByte ^ IN_CONST);
  assign w_newByte = gfInv(w_mapped);
  assign out_data  = r_data;

  // Next-state and handshake outputs. The FSM only listens to in_valid in
  // IDLE and to out_ready in DONE, so stray handshakes elsewhere are ignored.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == 4'd15) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus datapath. Reset wins over any handshake and wipes the
  // state so nothing of a partial result leaks out. In RUN one byte is
  // rewritten per edge; the 4-bit counter wraps to 0 after byte 15.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
      r_data  <= 128'h0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_count <= 4'd0;
          end
        end
        RUN: begin
          r_data[w_bitIdx +: 8] <= w_newByte;
          r_count               <= r_count + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbox_serial.sv
// ---------------------------------------------------------------------------
// tb_inv_sbox_serial
// Two instances share all inputs: dut uses IN_CONST = 8'h63 (InvSubBytes),
// dut0 uses IN_CONST = 8'h00 (pure inverse linear map + inverse). Expected
// results are queued when a state is accepted; a monitor pops and compares
// on each output handshake and checks the acceptance-to-valid latency.
// ---------------------------------------------------------------------------
module tb_inv_sbox_serial;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         in_ready,  out_valid,  busy;
  logic [127:0] out_data;
  logic         in_ready0, out_valid0, busy0;
  logic [127:0] out_data0;

  typedef struct {
    logic [127:0] e63;
    logic [127:0] e00;
    int           acceptEdge;
  } scoreT;

  scoreT      expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         edgeCount = 0;
  int         lastAccept = 0;
  logic [7:0] invTab[256];
  logic [7:0] expTab[255];

  inv_sbox_serial #(.IN_CONST(8'h63)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  inv_sbox_serial #(.IN_CONST(8'h00)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .busy(busy0)
  );

  // Free-running clock and an edge counter used for latency/spacing checks.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Reference model: inverse via powers of the generator 0x03, linear map via
  // byte rotations (rotl 1, 3, 6).
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  task automatic buildTables();
    logic [7:0] e;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      expTab[i] = e;
      e = e ^ xtime(e);
    end
    invTab[0] = 8'h00;
    for (int i = 0; i < 255; i++) invTab[expTab[i]] = expTab[(255 - i) % 255];
  endtask

  function automatic logic [7:0] refByte(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] t;
    logic [7:0] l;
    t = x ^ c;
    l = {t[6:0], t[7]} ^ {t[4:0], t[7:5]} ^ {t[1:0], t[7:2]};
    return invTab[l];
  endfunction

  function automatic logic [127:0] refState(input logic [127:0] d, input logic [7:0] c);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = refByte(d[8*k +: 8], c);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents a state and waits for it to be taken; the expected results are
  // queued together with the number of the accepting edge.
  task automatic applyStimulus(input logic [127:0] d, input logic [127:0] e63,
                               input logic [127:0] e00, input bit checkGap);
    int waitCycles;
    int accept;
    waitCycles = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 60) begin
      @(negedge clk); #1;
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    accept = edgeCount + 1;
    expQ.push_back('{e63, e00, accept});
    if (checkGap) checkOutput("accept_spacing", 128'(accept - lastAccept), 128'(18));
    lastAccept = accept;
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: runs just after the driver has settled its inputs each cycle.
  initial begin
    bit prevOV;
    scoreT s;
    prevOV = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        prevOV = 1'b0;
      end else begin
        if (out_valid && !prevOV && expQ.size() > 0)
          checkOutput("latency", 128'(edgeCount - expQ[0].acceptEdge), 128'(16));
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_output", out_data, 128'h0);
            errors += (out_data === 128'h0) ? 1 : 0;
          end else begin
            s = expQ.pop_front();
            checkOutput("data_c63", out_data, s.e63);
            checkOutput("data_c00", out_data0, s.e00);
            checkOutput("valid_c00", 128'(out_valid0), 128'(1));
          end
        end
        prevOV = out_valid;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] d;
    int           waitCycles;
    int           stray;

    buildTables();
    reset = 1'b1; in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_in_ready",  128'(in_ready),  128'(1));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_busy",      128'(busy),      128'(0));
    checkOutput("reset_out_data",  out_data,  128'h0);
    checkOutput("reset_out_data0", out_data0, 128'h0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Directed vectors with hand-known answers.
    out_ready = 1'b1;
    applyStimulus({16{8'h63}}, 128'h0, {16{8'h52}}, 1'b0);
    applyStimulus(128'h0, {16{8'h52}}, 128'h0, 1'b0);
    applyStimulus(128'h7C, {{15{8'h52}}, 8'h01}, refState(128'h7C, 8'h00), 1'b0);

    // Backpressure: stray in_valid in RUN/DONE, output held for 10 cycles.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 60) begin
      @(negedge clk); #1; waitCycles++;
    end
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(d, refState(d, 8'h63), refState(d, 8'h00), 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("run_in_ready", 128'(in_ready), 128'(0));
      checkOutput("run_busy",     128'(busy),     128'(1));
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    waitCycles = 0;
    while (!out_valid && waitCycles < 30) begin
      @(negedge clk); #1; waitCycles++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("hold_out_valid", 128'(out_valid), 128'(1));
      checkOutput("hold_out_data",  out_data, refState(d, 8'h63));
      checkOutput("hold_in_ready",  128'(in_ready), 128'(0));
      @(negedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("after_hold_in_ready",  128'(in_ready),  128'(1));
    checkOutput("after_hold_out_valid", 128'(out_valid), 128'(0));

    // Reset while the counter sits at 7.
    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(d, refState(d, 8'h63), refState(d, 8'h00), 1'b0);
    repeat (7) @(negedge clk);
    #1;
    reset = 1'b1;
    expQ.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    checkOutput("midrun_in_ready",  128'(in_ready),  128'(1));
    checkOutput("midrun_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midrun_busy",      128'(busy),      128'(0));
    checkOutput("midrun_out_data",  out_data,  128'h0);
    checkOutput("midrun_out_data0", out_data0, 128'h0);
    stray = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid) stray++;
    end
    checkOutput("midrun_no_valid", 128'(stray), 128'(0));
    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(d, refState(d, 8'h63), refState(d, 8'h00), 1'b0);

    // Random back-to-back traffic with out_ready held high.
    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(d, refState(d, 8'h63), refState(d, 8'h00), i > 0);
      if (i < 199) in_valid = 1'b1;
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 60) begin
      @(negedge clk); #1; waitCycles++;
    end
    checkOutput("drain", 128'(expQ.size()), 128'(0));
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
